// File: rtl/approx_sched_pkg.sv
// Shared types and helpers for the approximate-adder scheduler.
package approx_sched_pkg;

  function automatic int iw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int SCHED_SIZE = 8;
  localparam int SCHED_NREQ = 4;
  localparam int SCHED_IW   = iw_f(SCHED_NREQ);

  typedef struct packed {
    logic signed [SCHED_SIZE-1:0] a;
    logic signed [SCHED_SIZE-1:0] b;
    logic                         cin;
    logic                         approx;
    logic [SCHED_IW-1:0]          id;
  } s1_entry_t;

  typedef struct packed {
    logic signed [SCHED_SIZE-1:0] sum;
    logic                         cout;
    logic [SCHED_IW-1:0]          id;
  } s2_entry_t;

endpackage

// File: rtl/fa_nbits_sub.sv
// Ripple-carry adder; the low APPROX_BITS cells switch to an approximate
// full adder (sum = a|b, carry = a&b) when their approx_en bit is set.
module fa_nbits_sub #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic [SIZE-1:0] approx_en,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] carry;
  logic          unused_approx_en;

  assign carry[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_cell
    if (i < APPROX_BITS) begin : g_apx
      assign sum[i]     = approx_en[i] ? (a[i] | b[i]) : (a[i] ^ b[i] ^ carry[i]);
      assign carry[i+1] = approx_en[i] ? (a[i] & b[i])
                                       : ((a[i] & b[i]) | (carry[i] & (a[i] ^ b[i])));
    end else begin : g_exact
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[SIZE];
  // Exact cells ignore their enable bits.
  assign unused_approx_en = ^approx_en;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pointer and winner selection; grant gating is done by the parent.
module rr_arbiter
  import approx_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = iw_f(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [IW-1:0] ptr_q;

  // Scan from the far end so the entry closest to ptr wins last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx]) begin
        grant_idx = IW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/approx_adder_sched.sv
// Round-robin scheduler sharing one approximate adder among NREQ requesters
// through a two-stage (operand, result) pipeline.
module approx_adder_sched
  import approx_sched_pkg::*;
#(
  parameter  int SIZE        = SCHED_SIZE,
  parameter  int APPROX_BITS = 0,
  parameter  int NREQ        = SCHED_NREQ,
  localparam int IW          = iw_f(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][SIZE-1:0]  req_a,
  input  logic [NREQ-1:0][SIZE-1:0]  req_b,
  input  logic [NREQ-1:0]            req_cin,
  input  logic                       cfg_we,
  input  logic [IW-1:0]              cfg_idx,
  input  logic                       cfg_approx,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [SIZE-1:0]     res_sum,
  output logic                       res_cout,
  output logic [IW-1:0]              res_id
);

  // Pipeline entries are sized by the package constants.
  if (SIZE != SCHED_SIZE || IW != SCHED_IW) begin : g_bad_width
    $error("approx_adder_sched: SIZE/IW must match approx_sched_pkg entry widths");
  end

  s1_entry_t       ent_p1;
  logic            vld_p1;
  s2_entry_t       ent_p2;
  logic            vld_p2;
  logic [NREQ-1:0] flag_q;
  logic [NREQ-1:0] flag_d;
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;
  logic            s2_drain;
  logic            s1_advance;
  logic            s1_accept;
  logic            accept;
  logic [SIZE-1:0] add_sum;
  logic            add_cout;
  logic [SIZE-1:0] approx_en;

  assign s2_drain   = vld_p2 && res_ready;
  assign s1_advance = vld_p1 && (!vld_p2 || s2_drain);
  assign s1_accept  = !vld_p1 || s1_advance;
  assign accept     = !rst && s1_accept && grant_vld;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Out-of-range indices match no entry and are dropped.
  always_comb begin
    flag_d = flag_q;
    if (cfg_we) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cfg_idx == IW'(i)) flag_d[i] = cfg_approx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flag_q <= '0;
    else     flag_q <= flag_d;
  end

  // ---- S1: operand register, loaded at accept ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_accept) begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ent_p1.a      <= req_a[grant_idx];
      ent_p1.b      <= req_b[grant_idx];
      ent_p1.cin    <= req_cin[grant_idx];
      ent_p1.approx <= flag_q[grant_idx];
      ent_p1.id     <= grant_idx;
    end
  end

  assign approx_en = {SIZE{ent_p1.approx}};

  fa_nbits_sub #(
    .SIZE        (SIZE),
    .APPROX_BITS (APPROX_BITS)
  ) u_adder (
    .a         (ent_p1.a),
    .b         (ent_p1.b),
    .cin       (ent_p1.cin),
    .approx_en (approx_en),
    .sum       (add_sum),
    .cout      (add_cout)
  );

  // ---- S2: result register, holds while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      ent_p2 <= '0;
    end else if (s1_advance) begin
      vld_p2      <= 1'b1;
      ent_p2.sum  <= add_sum;
      ent_p2.cout <= add_cout;
      ent_p2.id   <= ent_p1.id;
    end else if (s2_drain) begin
      vld_p2 <= 1'b0;
    end
  end

  assign res_valid = vld_p2;
  assign res_sum   = ent_p2.sum;
  assign res_cout  = ent_p2.cout;
  assign res_id    = ent_p2.id;

endmodule

// File: tb/tb_approx_adder_sched.sv
// Randomized bench for approx_adder_sched against a queue-based behavioural model.
module tb_approx_adder_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        req_valid, req_ready, req_cin;
  logic [3:0][7:0]   req_a, req_b;
  logic              cfg_we, cfg_approx;
  logic [1:0]        cfg_idx;
  logic              res_valid, res_ready, res_cout;
  logic signed [7:0] res_sum;
  logic [1:0]        res_id;

  logic [2:0]        req_valid3, req_ready3, req_cin3;
  logic [2:0][7:0]   req_a3, req_b3;
  logic              cfg_we3, cfg_approx3;
  logic [1:0]        cfg_idx3;
  logic              res_valid3, res_cout3;
  logic signed [7:0] res_sum3;
  logic [1:0]        res_id3;

  approx_adder_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_approx(cfg_approx),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id)
  );

  approx_adder_sched #(.NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
    .cfg_we(cfg_we3), .cfg_idx(cfg_idx3), .cfg_approx(cfg_approx3),
    .res_valid(res_valid3), .res_ready(1'b1), .res_sum(res_sum3),
    .res_cout(res_cout3), .res_id(res_id3)
  );

  typedef struct {
    int         id;
    logic [7:0] sum;
    logic       cout;
    bit         apx;
    int         age;
  } op_t;

  op_t        q[$];
  int         m_ptr = 0;
  bit [3:0]   m_flag = '0;
  logic [7:0] lv_sum = '0;
  logic       lv_cout = 1'b0;
  logic [1:0] lv_id = '0;

  logic [15:0] obs_v, pred_v;
  logic [3:0]  o_rdy;
  logic        o_vld, o_cout;
  logic [7:0]  o_sum;
  logic [1:0]  o_id;

  int n_cmp = 0;
  int n_err = 0;

  // One clock: sample outputs at negedge, predict, then advance the model at posedge.
  task automatic tick();
    bit         drain, acc, pvld;
    int         w, s;
    logic [3:0] prdy;
    op_t        op;
    @(negedge clk);
    pvld = (q.size() > 0) && (q[0].age >= 1);
    if (pvld) begin
      lv_sum  = q[0].sum;
      lv_cout = q[0].cout;
      lv_id   = 2'(q[0].id);
    end
    drain = pvld && res_ready;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    acc  = !rst && (w >= 0) && (q.size() < 2 || drain);
    prdy = acc ? 4'(1 << w) : 4'b0;
    pred_v = {prdy, pvld, lv_sum, lv_cout, lv_id};
    obs_v  = {req_ready, res_valid, res_sum, res_cout, res_id};
    {o_rdy, o_vld, o_sum, o_cout, o_id} = obs_v;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr = 0; m_flag = '0;
      lv_sum = '0; lv_cout = 1'b0; lv_id = '0;
    end else begin
      if (drain) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) begin
        s = int'(req_a[w]) + int'(req_b[w]) + int'(req_cin[w]);
        op.id = w; op.sum = s[7:0]; op.cout = s[8]; op.apx = m_flag[w]; op.age = 0;
        q.push_back(op);
        m_ptr = (w + 1) % 4;
      end
      if (cfg_we) m_flag[cfg_idx] = cfg_approx;
    end
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 8'($urandom); req_b[i] = 8'($urandom); req_cin[i] = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs_v !== pred_v) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", obs_v, pred_v); end
    n_cmp++;
    if (obs_v !== 16'h0) begin n_err++; $display("FAIL reset_zero: got %h expected 0000", obs_v); end
    n_cmp++;
    if (dut.u_arb.ptr_q !== 2'd0 || dut.flag_q !== 4'd0) begin
      n_err++; $display("FAIL reset_state: ptr %0d flags %b expected 0 0000", dut.u_arb.ptr_q, dut.flag_q);
    end
  endtask

  task automatic test_single_op();
    res_ready = 1'b1;
    req_valid = 4'b0100; req_a[2] = 8'd5; req_b[2] = 8'd3; req_cin[2] = 1'b1;
    tick();
    n_cmp++;
    if (o_rdy !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b expected 0100", o_rdy); end
    req_valid = 4'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL single_cycle%0d: got %h expected %h", c, obs_v, pred_v); end
    end
    n_cmp++;
    if ({o_vld, o_sum, o_cout, o_id} !== {1'b1, 8'd9, 1'b0, 2'd2})
      begin n_err++; $display("FAIL single_result: got vld %b sum %0d cout %b id %0d expected 1 9 0 2", o_vld, o_sum, o_cout, o_id); end
  endtask

  task automatic test_wrap();
    logic [8:0] want [2];
    want[0] = {1'b0, 8'h80}; want[1] = {1'b1, 8'h00};
    res_ready = 1'b1;
    req_valid = 4'b0001; req_a[0] = 8'h7F; req_b[0] = 8'h01; req_cin[0] = 1'b0;
    tick();
    req_a[0] = 8'hFF;
    tick();
    req_valid = 4'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL wrap_cycle%0d: got %h expected %h", c, obs_v, pred_v); end
      n_cmp++;
      if ({o_vld, o_cout, o_sum} !== {1'b1, want[c]})
        begin n_err++; $display("FAIL wrap_result%0d: got vld %b cout %b sum %h expected 1 %h", c, o_vld, o_cout, o_sum, want[c]); end
    end
  endtask

  task automatic test_fairness();
    int ids[$];
    rst = 1'b1; tick(); rst = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = 4'b0;
      rand_ops();
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL fair_cycle%0d: got %h expected %h", k, obs_v, pred_v); end
      if (k < 8) begin
        n_cmp++;
        if (o_rdy !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL fair_grant%0d: got %b expected %b", k, o_rdy, 4'(1 << (k % 4))); end
      end
      if (o_vld) ids.push_back(int'(o_id));
    end
    n_cmp++;
    if (ids.size() != 8) begin n_err++; $display("FAIL fair_count: got %0d expected 8", ids.size()); end
    foreach (ids[i]) begin
      n_cmp++;
      if (ids[i] != i % 4) begin n_err++; $display("FAIL fair_res_id%0d: got %0d expected %0d", i, ids[i], i % 4); end
    end
  endtask

  task automatic test_back_pressure();
    int acc_ids[$], out_ids[$];
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL bp_hold%0d: got %h expected %h", k, obs_v, pred_v); end
      for (int i = 0; i < 4; i++) if (o_rdy[i]) acc_ids.push_back(i);
    end
    n_cmp++;
    if (acc_ids.size() != 2 || o_rdy !== 4'b0)
      begin n_err++; $display("FAIL bp_accepts: got %0d accepts, ready %b expected 2, 0000", acc_ids.size(), o_rdy); end
    res_ready = 1'b1;
    req_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL bp_drain%0d: got %h expected %h", k, obs_v, pred_v); end
      if (o_vld) out_ids.push_back(int'(o_id));
    end
    n_cmp++;
    if (out_ids != acc_ids) begin n_err++; $display("FAIL bp_order: got %p expected %p", out_ids, acc_ids); end
  endtask

  task automatic test_config();
    logic [7:0] want [4];
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'hFF;
    res_ready = 1'b1;
    req_valid = 4'b0;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_approx = 1'b1;
    tick();
    cfg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = (k == 0) ? 4'b0010 : 4'b0001;
      rand_ops();
      cfg_we = (k == 2); cfg_idx = 2'd0; cfg_approx = 1'b1;
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL cfg_cycle%0d: got %h expected %h", k, obs_v, pred_v); end
      n_cmp++;
      if (dut.u_adder.approx_en !== want[k])
        begin n_err++; $display("FAIL cfg_approx_en%0d: got %h expected %h", k, dut.u_adder.approx_en, want[k]); end
    end
    cfg_we = 1'b0;
    req_valid = 4'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs_v !== pred_v) begin n_err++; $display("FAIL rstmid_during: got %h expected %h", obs_v, pred_v); end
    rst = 1'b0;
    req_valid = 4'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (o_vld !== 1'b0 || obs_v !== pred_v)
        begin n_err++; $display("FAIL rstmid_after%0d: got %h expected %h", k, obs_v, pred_v); end
    end
    n_cmp++;
    if (dut.u_arb.ptr_q !== 2'd0 || dut.flag_q !== 4'd0)
      begin n_err++; $display("FAIL rstmid_state: ptr %0d flags %b expected 0 0000", dut.u_arb.ptr_q, dut.flag_q); end
  endtask

  task automatic test_cfg_oob();
    logic [2:0] want [3];
    logic [1:0] idx [3];
    logic       val [3];
    idx[0] = 2'd2; val[0] = 1'b1; want[0] = 3'b100;
    idx[1] = 2'd3; val[1] = 1'b1; want[1] = 3'b100;
    idx[2] = 2'd3; val[2] = 1'b0; want[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      cfg_we3 = 1'b1; cfg_idx3 = idx[k]; cfg_approx3 = val[k];
      @(posedge clk); #1;
      n_cmp++;
      if (dut3.flag_q !== want[k]) begin n_err++; $display("FAIL cfg_oob%0d: got %b expected %b", k, dut3.flag_q, want[k]); end
    end
    cfg_we3 = 1'b0;
  endtask

  task automatic test_random();
    op_t s1;
    bit  have_s1;
    for (int k = 0; k < 400; k++) begin
      req_valid  = 4'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_idx    = 2'($urandom);
      cfg_approx = 1'($urandom);
      rst        = ($urandom_range(0, 99) == 0);
      rand_ops();
      tick();
      n_cmp++;
      if (obs_v !== pred_v) begin n_err++; $display("FAIL rand_cycle%0d: got %h expected %h", k, obs_v, pred_v); end
      have_s1 = 1'b0;
      if (q.size() > 0 && q[0].age == 0) begin s1 = q[0]; have_s1 = 1'b1; end
      else if (q.size() > 1) begin s1 = q[1]; have_s1 = 1'b1; end
      if (have_s1) begin
        n_cmp++;
        if (dut.u_adder.approx_en !== {8{s1.apx}})
          begin n_err++; $display("FAIL rand_approx%0d: got %h expected %h", k, dut.u_adder.approx_en, {8{s1.apx}}); end
      end
    end
    rst = 1'b0; cfg_we = 1'b0; req_valid = 4'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_approx = 1'b0; res_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_cin3 = '0;
    cfg_we3 = 1'b0; cfg_idx3 = '0; cfg_approx3 = 1'b0;
    test_reset();
    test_single_op();
    test_wrap();
    test_fairness();
    test_back_pressure();
    test_config();
    test_reset_mid();
    test_cfg_oob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_adder_sched.md
# approx_adder_sched

Round-robin scheduler that shares one approximate ripple-carry adder among NREQ requesters in the DCT datapath. Each requester presents operands with a valid/ready handshake. The block arbitrates, tags the operation with the winner's per-requester approximation setting, runs it through a two-stage pipeline around the adder, and returns sum/cout with the requester ID on a single valid/ready result port.

## Interface
- SIZE, 8, operand/sum width in bits
- APPROX_BITS, 0, LSBs built from approximate cells; passed unchanged to the adder
- NREQ, 4, requester count, ≥2; IW = $clog2(NREQ)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  operation offered, one bit per requester
- req_ready  out  NREQ  one-hot-or-zero; accept strobe
- req_a, req_b  in  NREQ×SIZE  signed operands per requester
- req_cin  in  NREQ  carry-in per requester
- cfg_we  in  1  write approximation flag
- cfg_idx  in  IW  requester whose flag is written
- cfg_approx  in  1  flag value; 1 = approximate mode
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  SIZE  signed sum
- res_cout  out  1  carry out of MSB
- res_id  out  IW  requester that issued the operation

## Operation
- Stage S1 is an operand register: a, b, cin, approx flag, id, s1_valid. Stage S2 is the result register: sum, cout, id, s2_valid. The adder sits combinationally between S1 and S2.
- S2 drains when res_valid && res_ready. S2 loads when S1 is valid and (S2 is empty or drains this cycle). Load and drain in the same cycle is legal.
- S1 accepts when S1 is empty or S1 advances this cycle. Otherwise every req_ready bit is 0.
- Arbitration: a round-robin pointer ptr gives the winner, which is the first i in ptr, ptr+1, … (mod NREQ) with req_valid[i]=1. req_ready[winner]=1 only if S1 accepts. After an accept, ptr ← winner+1 mod NREQ. With no accept, ptr holds.
- Approx flags are NREQ bits of register state. On cfg_we with cfg_idx<NREQ, flag[cfg_idx] ← cfg_approx. Writes with cfg_idx≥NREQ are ignored.
- The flag is sampled into S1 at accept. A write in the same cycle as an accept for that requester is not seen; the old value is used.
- Adder wiring: approx_en bus is SIZE bits, all driven by the S1 flag. Sum wraps mod 2^SIZE (two's complement). cout is the raw carry out of bit SIZE-1.
- Each of res_sum, res_cout and res_id must stay stable while res_valid && !res_ready.

## Timing
- Reset values: req_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0. Also ptr=0, all flags=0, s1_valid=0.
- Latency: an accept at edge t gives res_valid=1 after edge t+1, i.e. two edges from accept to result.
- Throughput is one operation per cycle when res_ready is held high.
- Back-pressure: with res_ready=0 the pipeline fills. S2 holds, then S1 holds, then req_ready goes to 0. Up to 2 operations are in flight.
- Reset mid-operation drops in-flight operations with no result emitted. The flags return to 0.
- req_ready is a combinational function of req_valid, the state and res_ready. It has no combinational path from req_a, req_b or req_cin.

## Structure
- Shared package approx_sched_pkg holds:
  - a typedef for the S1 entry (a, b, cin, approx, id)
  - a typedef for the S2 entry (sum, cout, id)
  - the IW width function
- Sub-modules:
  - the existing ripple adder fa_nbits_sub, instanced once with SIZE and APPROX_BITS passed through
  - rr_arbiter (NREQ), for the pointer and winner logic; req_ready is gated in the parent.

## Test plan
- Reset, then a single op: requester 2 sends a=5, b=3, cin=1. Expect res_sum=9, res_cout=0, res_id=2 two edges after accept.
- Wrap and carry with SIZE=8: a=0x7F, b=0x01, cin=0 gives sum=0x80, cout=0. a=0xFF, b=0x01 gives sum=0x00, cout=1.
- Fairness: all four req_valid held high, res_ready=1, for 8 accepts. Grants must be 0,1,2,3,0,1,2,3, and res_id must follow the same order.
- Back-pressure: res_ready=0 for 5 cycles with requests present. Expect exactly 2 accepts, then req_ready=0 and res_* stable. On release, results drain in order with no loss or duplication.
- Config: write flag[1]=1, then send an op from 1 and an op from 0. The adder approx_en must be all-ones for the requester-1 op and all-zeros for the requester-0 op. A same-cycle write and accept must use the old flag. A write with cfg_idx=NREQ must be ignored.
- Assert rst with 2 ops in flight. Expect res_valid=0 on the next cycle, ptr=0, flags cleared, and no stale result afterwards.
